// File: rtl/sm_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : sm_accumulator
//  Description : Multi-channel sign-magnitude accumulator. Each accepted
//                sample is added to (or subtracted from) its channel's running
//                sum. Two-stage pipeline: stage 1 registers the sample, stage 2
//                performs the add, writes the channel accumulator and drives
//                the result. Overflow detection with optional saturation,
//                per-channel sticky overflow flags, and canonical +0.
//  Ports       : clk          - rising-edge clock
//                rst_n        - asynchronous active-low reset
//                in_valid_i   - sample strobe (no backpressure)
//                in_chan_i    - target channel (>= CHANNELS ignored)
//                in_data_i    - sign-magnitude operand, sign at bit WIDTH
//                in_sub_i     - subtract operand (invert its sign)
//                in_clear_i   - treat stored sum as +0 for this sample
//                out_valid_o  - single-cycle result strobe
//                out_chan_o   - channel of the result
//                out_data_o   - new accumulator value, sign-magnitude
//                out_ovf_o    - the add producing out_data_o overflowed
//                ovf_sticky_o - per-channel sticky overflow flags
//  Revision    : 1.0 - initial release
// ============================================================================
module sm_accumulator #(
  parameter int WIDTH    = 31,
  parameter int CHANNELS = 4,
  parameter int SATURATE = 1
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    in_valid_i,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] in_chan_i,
  input  logic [WIDTH:0]                          in_data_i,
  input  logic                                    in_sub_i,
  input  logic                                    in_clear_i,
  output logic                                    out_valid_o,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] out_chan_o,
  output logic [WIDTH:0]                          out_data_o,
  output logic                                    out_ovf_o,
  output logic [CHANNELS-1:0]                     ovf_sticky_o
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  // Stage 1 registers
  logic           s1_valid_q;
  logic [CW-1:0]  s1_chan_q;
  logic [WIDTH:0] s1_data_q;
  logic           s1_clear_q;

  // Accumulator state
  logic [WIDTH:0]    acc_q [CHANNELS];
  logic [CHANNELS-1:0] sticky_q;

  // Output registers
  logic           out_valid_q;
  logic [CW-1:0]  out_chan_q;
  logic [WIDTH:0] out_data_q;
  logic           out_ovf_q;

  // Stage 2 combinational datapath
  logic [WIDTH:0]   a_w;
  logic [WIDTH-1:0] mag_a_w;
  logic [WIDTH-1:0] mag_b_w;
  logic             sign_a_w;
  logic             sign_b_w;
  logic [WIDTH:0]   sum_w;
  logic             a_ge_b_w;
  logic [WIDTH-1:0] mag_r_w;
  logic             sign_r_w;
  logic             ovf_w;
  logic [WIDTH:0]   res_d;

  // Out-of-range channels are dropped here so stage 2 never sees them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_chan_q  <= '0;
      s1_data_q  <= '0;
      s1_clear_q <= 1'b0;
    end else begin
      s1_valid_q <= in_valid_i && (32'(in_chan_i) < CHANNELS);
      if (in_valid_i) begin
        s1_chan_q  <= in_chan_i;
        s1_data_q  <= {in_data_i[WIDTH] ^ in_sub_i, in_data_i[WIDTH-1:0]};
        s1_clear_q <= in_clear_i;
      end
    end
  end

  // The array read sees the previous cycle's write, so back-to-back samples
  // on one channel accumulate exactly without a bypass path.
  always_comb begin
    a_w      = s1_clear_q ? '0 : acc_q[s1_chan_q];
    mag_a_w  = a_w[WIDTH-1:0];
    mag_b_w  = s1_data_q[WIDTH-1:0];
    // A zero magnitude is +0 regardless of its sign bit.
    sign_a_w = a_w[WIDTH] & (|mag_a_w);
    sign_b_w = s1_data_q[WIDTH] & (|mag_b_w);
    sum_w    = {1'b0, mag_a_w} + {1'b0, mag_b_w};
    a_ge_b_w = (mag_a_w >= mag_b_w);
    ovf_w    = 1'b0;
    if (sign_a_w == sign_b_w) begin
      ovf_w    = sum_w[WIDTH];
      sign_r_w = sign_a_w;
      mag_r_w  = (ovf_w && (SATURATE != 0)) ? '1 : sum_w[WIDTH-1:0];
    end else if (a_ge_b_w) begin
      sign_r_w = sign_a_w;
      mag_r_w  = mag_a_w - mag_b_w;
    end else begin
      sign_r_w = sign_b_w;
      mag_r_w  = mag_b_w - mag_a_w;
    end
    // Never produce -0 (also covers a wrapped sum landing on zero).
    res_d = {sign_r_w & (|mag_r_w), mag_r_w};
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic wr_w;
      assign wr_w = s1_valid_q && (s1_chan_q == CW'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_q[gi]    <= '0;
          sticky_q[gi] <= 1'b0;
        end else if (wr_w) begin
          acc_q[gi]    <= res_d;
          // A clear drops the old flag before this sample's overflow is merged.
          sticky_q[gi] <= (sticky_q[gi] & ~s1_clear_q) | ovf_w;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_chan_q <= s1_chan_q;
        out_data_q <= res_d;
        out_ovf_q  <= ovf_w;
      end
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_chan_o   = out_chan_q;
  assign out_data_o   = out_data_q;
  assign out_ovf_o    = out_ovf_q;
  assign ovf_sticky_o = sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_sm_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sm_accumulator
//  Description : Self-checking bench for sm_accumulator. Two instances
//                (saturating and wrapping, WIDTH=7, CHANNELS=5) share one
//                stimulus stream; a reference model pushes expected results
//                into per-instance queues that monitors pop on out_valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sm_accumulator;

  localparam int WIDTH    = 7;
  localparam int CHANNELS = 5;
  localparam int CW       = 3;

  typedef struct packed {
    logic [CW-1:0]       chan;
    logic [WIDTH:0]      data;
    logic                ovf;
    logic [CHANNELS-1:0] sticky;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic [CW-1:0]       in_chan = '0;
  logic [WIDTH:0]      in_data = '0;
  logic                in_sub = 1'b0;
  logic                in_clear = 1'b0;

  logic                s_valid, w_valid;
  logic [CW-1:0]       s_chan, w_chan;
  logic [WIDTH:0]      s_data, w_data;
  logic                s_ovf, w_ovf;
  logic [CHANNELS-1:0] s_sticky, w_sticky;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q_sat[$];
  exp_t q_wrap[$];
  logic [WIDTH:0]      m_acc_sat [CHANNELS];
  logic [WIDTH:0]      m_acc_wrap[CHANNELS];
  logic [CHANNELS-1:0] m_st_sat, m_st_wrap;

  always #5 clk = ~clk;

  sm_accumulator #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_chan_i(in_chan),
    .in_data_i(in_data), .in_sub_i(in_sub), .in_clear_i(in_clear),
    .out_valid_o(s_valid), .out_chan_o(s_chan), .out_data_o(s_data),
    .out_ovf_o(s_ovf), .ovf_sticky_o(s_sticky)
  );

  sm_accumulator #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SATURATE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_chan_i(in_chan),
    .in_data_i(in_data), .in_sub_i(in_sub), .in_clear_i(in_clear),
    .out_valid_o(w_valid), .out_chan_o(w_chan), .out_data_o(w_data),
    .out_ovf_o(w_ovf), .ovf_sticky_o(w_sticky)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: returns {ovf, sign, magnitude}.
  function automatic logic [WIDTH+1:0] sm_model(input logic [WIDTH:0] a,
                                                 input logic [WIDTH:0] b,
                                                 input bit sat);
    int ma, mb, m;
    bit sa, sb, s, ovf;
    ma  = int'(a[WIDTH-1:0]);
    mb  = int'(b[WIDTH-1:0]);
    sa  = a[WIDTH] && (ma != 0);
    sb  = b[WIDTH] && (mb != 0);
    ovf = 1'b0;
    if (sa == sb) begin
      m = ma + mb;
      s = sa;
      if (m > 127) begin
        ovf = 1'b1;
        m   = sat ? 127 : m - 128;
      end
    end else if (ma >= mb) begin
      m = ma - mb;
      s = sa;
    end else begin
      m = mb - ma;
      s = sb;
    end
    if (m == 0) s = 1'b0;
    return {ovf, s, m[WIDTH-1:0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CHANNELS; i++) begin
      m_acc_sat[i]  = '0;
      m_acc_wrap[i] = '0;
    end
    m_st_sat  = '0;
    m_st_wrap = '0;
    q_sat.delete();
    q_wrap.delete();
  endtask

  task automatic send(input int chan, input logic [WIDTH:0] data,
                      input bit sub, input bit clear);
    logic [WIDTH:0]   a, b;
    logic [WIDTH+1:0] r;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_chan  = CW'(chan);
    in_data  = data;
    in_sub   = sub;
    in_clear = clear;
    if (chan < CHANNELS) begin
      b = {data[WIDTH] ^ sub, data[WIDTH-1:0]};
      a = clear ? '0 : m_acc_sat[chan];
      r = sm_model(a, b, 1'b1);
      m_acc_sat[chan] = r[WIDTH:0];
      m_st_sat[chan]  = (clear ? 1'b0 : m_st_sat[chan]) | r[WIDTH+1];
      e = '{chan: CW'(chan), data: r[WIDTH:0], ovf: r[WIDTH+1], sticky: m_st_sat};
      q_sat.push_back(e);
      a = clear ? '0 : m_acc_wrap[chan];
      r = sm_model(a, b, 1'b0);
      m_acc_wrap[chan] = r[WIDTH:0];
      m_st_wrap[chan]  = (clear ? 1'b0 : m_st_wrap[chan]) | r[WIDTH+1];
      e = '{chan: CW'(chan), data: r[WIDTH:0], ovf: r[WIDTH+1], sticky: m_st_wrap};
      q_wrap.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sub   = 1'b0;
      in_clear = 1'b0;
    end
  endtask

  // Scoreboard monitors, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst_n && s_valid) begin
      if (q_sat.size() == 0) begin
        check("sat_unexpected_valid", 32'(s_valid), 32'd0);
      end else begin
        exp_t e;
        e = q_sat.pop_front();
        check("sat_chan",   32'(s_chan),   32'(e.chan));
        check("sat_data",   32'(s_data),   32'(e.data));
        check("sat_ovf",    32'(s_ovf),    32'(e.ovf));
        check("sat_sticky", 32'(s_sticky), 32'(e.sticky));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && w_valid) begin
      if (q_wrap.size() == 0) begin
        check("wrap_unexpected_valid", 32'(w_valid), 32'd0);
      end else begin
        exp_t e;
        e = q_wrap.pop_front();
        check("wrap_chan",   32'(w_chan),   32'(e.chan));
        check("wrap_data",   32'(w_data),   32'(e.data));
        check("wrap_ovf",    32'(w_ovf),    32'(e.ovf));
        check("wrap_sticky", 32'(w_sticky), 32'(e.sticky));
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    // Idle after reset: every output must read zero.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("reset_idle_sat",
            {16'd0, s_valid, s_chan, s_data, s_ovf, s_sticky}, 32'd0);
      check("reset_idle_wrap",
            {16'd0, w_valid, w_chan, w_data, w_ovf, w_sticky}, 32'd0);
    end

    // Accumulate on ch1: +5, +8, -2
    send(1, 8'h05, 1'b0, 1'b1);
    send(1, 8'h03, 1'b0, 1'b0);
    send(1, 8'h0A, 1'b1, 1'b0);
    // Cancel to zero on ch0, then -0 operands
    send(0, 8'h07, 1'b0, 1'b1);
    send(0, 8'h07, 1'b1, 1'b0);
    send(0, 8'h80, 1'b0, 1'b0);
    send(0, 8'h04, 1'b0, 1'b0);
    send(0, 8'h80, 1'b1, 1'b0);
    // Overflow on ch2, recovery, then clear of the sticky flag
    send(2, 8'h64, 1'b0, 1'b1);
    send(2, 8'h64, 1'b0, 1'b0);
    send(2, 8'h9B, 1'b0, 1'b0);
    send(2, 8'h01, 1'b0, 1'b1);
    // Negative overflow on ch3: clear-120, then -10
    send(3, 8'hF8, 1'b0, 1'b1);
    send(3, 8'h8A, 1'b0, 1'b0);
    // Wrap landing exactly on zero magnitude (64 + 64)
    send(4, 8'hC0, 1'b0, 1'b1);
    send(4, 8'hC0, 1'b0, 1'b0);
    // Interleave ch0 and ch3
    for (int i = 0; i < 4; i++) begin
      send(0, 8'h01, 1'b0, i == 0);
      send(3, 8'h02, 1'b0, i == 0);
    end
    idle(4);
    check("drain1_sat",  32'(q_sat.size()),  32'd0);
    check("drain1_wrap", 32'(q_wrap.size()), 32'd0);

    // Invalid channels: no pulse, no sum change
    send(CHANNELS, 8'h09, 1'b0, 1'b0);
    send(7, 8'h11, 1'b0, 1'b1);
    idle(4);
    send(0, 8'h01, 1'b0, 1'b0);
    send(3, 8'h01, 1'b0, 1'b0);
    idle(4);
    check("drain2_sat",  32'(q_sat.size()),  32'd0);
    check("drain2_wrap", 32'(q_wrap.size()), 32'd0);

    // Reset mid-stream
    send(0, 8'h05, 1'b0, 1'b0);
    send(0, 8'h06, 1'b0, 1'b0);
    @(posedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_valid_sat",  32'(s_valid), 32'd0);
    check("midreset_valid_wrap", 32'(w_valid), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    send(0, 8'h03, 1'b0, 1'b0);
    idle(5);
    check("drain3_sat",  32'(q_sat.size()),  32'd0);
    check("drain3_wrap", 32'(q_wrap.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sm_accumulator.md
Name: sm_accumulator

Overview:
- Multi-channel sign-magnitude accumulator for the mixed IIR filter datapath.
- Keeps one running sum per channel, using the same [WIDTH] sign / [WIDTH-1:0] magnitude word format as the filter's combinational adders.
- Each accepted sample is added to, or subtracted from, its channel's sum.
- Improves on the plain adder with a pipelined datapath, carry-out overflow detection, optional saturation, per-channel clear and canonical zero.

Parameters:
- WIDTH, 31, index of the sign bit; words are WIDTH+1 bits wide with a WIDTH-bit magnitude.
- CHANNELS, 4, number of independent accumulators (>=1).
- SATURATE, 1, 1 = clamp to max magnitude on overflow; 0 = wrap (carry-out dropped).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  sample strobe; the block accepts every cycle, with no backpressure.
- in_chan  input  max(1,$clog2(CHANNELS))  target channel; values >= CHANNELS are ignored (no write, no output).
- in_data  input  WIDTH+1  sign-magnitude operand.
- in_sub  input  1  1 = subtract in_data (sign bit inverted before the add).
- in_clear  input  1  1 = treat the stored sum as +0 for this sample (load operand).
- out_valid  output  1  result strobe.
- out_chan  output  max(1,$clog2(CHANNELS))  channel of the result.
- out_data  output  WIDTH+1  new accumulator value, sign-magnitude.
- out_ovf  output  1  the add producing out_data overflowed.
- ovf_sticky  output  CHANNELS  per-channel sticky overflow flags; cleared by in_clear on that channel or by reset.

Behaviour:
- Reset (async assert, sync release): all accumulators +0, stage-1 valid 0, out_valid 0, out_chan 0, out_data 0, out_ovf 0, ovf_sticky 0. A reset mid-operation discards any in-flight sample.
- Stage 1 (edge t): register in_valid, in_chan, in_data with sign XOR in_sub, and in_clear.
- Stage 2 (edge t+1):
  - A = in_clear ? +0 : acc[chan]; B = the registered operand.
  - Compute R; write acc[chan] <= R; drive out_* with out_valid=1.
  - Latency from input to output is 2 edges. Throughput is one sample per cycle.
- Back-to-back samples on the same channel need no stall. Stage 2 reads the array after the previous cycle's write, so the accumulation is exact; this property is required.
- Arithmetic, with magnitudes extended to WIDTH+1 bits:
  - Equal signs: M = |A|+|B|; sign = the common sign; overflow = M[WIDTH].
  - Different signs: subtract the smaller magnitude from the larger; the sign is that of the larger; equal magnitudes give +0. Overflow is never set.
  - Zero handling: inputs with zero magnitude are treated as +0, whatever their sign bit. A zero-magnitude result always has the sign bit cleared, so -0 is never produced.
- On overflow:
  - SATURATE=1: R = {sign, all-ones magnitude}.
  - SATURATE=0: R = {sign, M[WIDTH-1:0]}.
  - In both modes: out_ovf=1 and ovf_sticky[chan] set.
- in_clear with overflow: in_clear clears ovf_sticky[chan] before it is evaluated for this sample. A clear-load cannot overflow, so the flag ends at 0.
- in_valid=0 or invalid channel: no array write; out_valid=0 next cycle. out_chan, out_data and out_ovf hold their last values.
- out_valid is a single-cycle pulse per accepted sample.

Test Plan:
- Reset/idle: hold rst_n=0 then release with in_valid=0 -> all outputs 0 for 10 cycles; assert rst_n low mid-stream -> out_valid drops immediately, and the next sample on ch0 gives a sum starting from +0.
- Accumulate/latency: ch1, clear+5, then +3, then -10 on consecutive cycles -> out_data = +5, +8, -2 (sign=1, mag=2) on cycles t+2, t+3, t+4, each with out_chan=1.
- Cancel to zero: ch0, clear+7, then in_data=+7 with in_sub=1 -> out_data=0, with the sign bit 0. Also send -0 as an operand -> the sum is unchanged and the sign is not flipped.
- Saturation (WIDTH=7, SATURATE=1): ch2, clear+100, then +100 -> out_data=0x7F, out_ovf=1, ovf_sticky[2]=1. A following -27 gives +100 and the sticky flag stays 1. A clear+1 -> ovf_sticky[2]=0.
- Wrap mode (WIDTH=7, SATURATE=0): clear-120, then -10 -> magnitude 130 mod 128 = 2, out_data = sign 1 / mag 2, out_ovf=1.
- Channel interleave and invalid channel: alternate ch0 +1 and ch3 +2 for 8 cycles -> final sums +4 and +8. A sample with in_chan=CHANNELS (if representable) -> no out_valid pulse and no sum changes.
